// File: rtl/fir_ctrl_pkg.sv
// rtl/fir_ctrl_pkg.sv - shared types and constants for the FIR coefficient controller
// Purpose: FSM state encoding plus helpers for the reset coefficient set.
// Contents:
//   state_t      - controller FSM states
//   unity_value  - integer value of 1.0 for a given number of fractional bits
//   center_tap   - index of the center tap for a given tap count
package fir_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2,
    ST_SWAP  = 2'd3
  } state_t;

  function automatic int unity_value(input int nbfcoeff);
    return 1 << nbfcoeff;
  endfunction

  function automatic int center_tap(input int ncoeff);
    return (ncoeff - 1) / 2;
  endfunction

endpackage

// File: rtl/fir_strobe_gen.sv
// rtl/fir_strobe_gen.sv - sample-enable strobe generator, one pulse every OS_DIV clocks
// Purpose: divides the clock into the FIR sample strobe while run is high.
// Ports:
//   clk    in   system clock
//   reset  in   asynchronous active-high reset
//   run    in   enables counting; low clears the counter and the strobe
//   enable out  registered strobe, one clk wide (steady high when OS_DIV = 1)
module fir_strobe_gen #(
  parameter int OS_DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic enable
);

  localparam int CW = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(OS_DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt    <= '0;
      enable <= 1'b0;
    end else if (run) begin
      cnt    <= (cnt == LAST) ? '0 : cnt + 1'b1;
      enable <= (cnt == LAST);
    end else begin
      cnt    <= '0;
      enable <= 1'b0;
    end
  end

endmodule

// File: rtl/fir_coeff_ctrl.sv
// rtl/fir_coeff_ctrl.sv - FIR sequencer with shadow/active coefficient banks
// Purpose: generates the FIR sample strobe, loads a serial coefficient stream into a
// shadow bank and, on commit, copies it into the active bank on a strobe edge.
// Ports:
//   clk, reset    clock and asynchronous active-high reset
//   i_run         enables strobe generation
//   i_load_start  begin or restart a shadow load
//   i_wr_valid    coefficient word valid; i_wr_data carries it, tap 0 first
//   o_wr_ready    shadow bank accepting words
//   i_commit      request active <- shadow swap
//   o_coeff       active bank, tap i at [NBCOEFF*(i+1)-1 -: NBCOEFF]
//   o_enable      FIR sample strobe
//   o_busy        FSM not idle
//   o_swapped     one-cycle pulse after a swap
//   o_err         one-cycle pulse on a commit outside ARMED
module fir_coeff_ctrl
  import fir_ctrl_pkg::*;
#(
  parameter int NCOEFF   = 9,
  parameter int NBCOEFF  = 7,
  parameter int NBFCOEFF = 5,
  parameter int OS_DIV   = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_run,
  input  logic                      i_load_start,
  input  logic                      i_wr_valid,
  input  logic [NBCOEFF-1:0]        i_wr_data,
  output logic                      o_wr_ready,
  input  logic                      i_commit,
  output logic [NCOEFF*NBCOEFF-1:0] o_coeff,
  output logic                      o_enable,
  output logic                      o_busy,
  output logic                      o_swapped,
  output logic                      o_err
);

  localparam int WIDX_W = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
  localparam int CTR    = center_tap(NCOEFF);
  localparam logic [NBCOEFF-1:0] UNITY    = NBCOEFF'(unity_value(NBFCOEFF));
  localparam logic [WIDX_W-1:0]  LAST_IDX = WIDX_W'(NCOEFF - 1);

  state_t              state, state_next;
  logic [WIDX_W-1:0]   widx, widx_next;
  logic                wr_en;
  logic                swap_en;
  logic                err_next;
  logic [NBCOEFF-1:0]  shadow [NCOEFF];
  logic [NBCOEFF-1:0]  active [NCOEFF];

  fir_strobe_gen #(
    .OS_DIV (OS_DIV)
  ) u_strobe (
    .clk    (clk),
    .reset  (reset),
    .run    (i_run),
    .enable (o_enable)
  );

  always_comb begin
    state_next = state;
    widx_next  = widx;
    wr_en      = 1'b0;
    swap_en    = 1'b0;
    err_next   = 1'b0;
    o_wr_ready = 1'b0;
    o_busy     = (state != ST_IDLE);
    case (state)
      ST_IDLE: begin
        if (i_load_start) begin
          state_next = ST_LOAD;
          widx_next  = '0;
        end else if (i_commit) begin
          err_next = 1'b1;
        end
      end
      ST_LOAD: begin
        o_wr_ready = 1'b1;
        err_next   = i_commit;
        // A restart discards any word presented in the same cycle.
        if (i_load_start) begin
          widx_next = '0;
        end else if (i_wr_valid) begin
          wr_en = 1'b1;
          if (widx == LAST_IDX) begin
            state_next = ST_ARMED;
            widx_next  = '0;
          end else begin
            widx_next = widx + 1'b1;
          end
        end
      end
      ST_ARMED: begin
        if (i_load_start) begin
          state_next = ST_LOAD;
          widx_next  = '0;
        end else if (i_commit) begin
          state_next = ST_SWAP;
        end
      end
      ST_SWAP: begin
        // Swap on a strobe edge: the FIR still captures the old set at this
        // edge and sees the complete new set at the next strobe.
        if (o_enable) begin
          swap_en    = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      widx      <= '0;
      o_swapped <= 1'b0;
      o_err     <= 1'b0;
      for (int i = 0; i < NCOEFF; i++) begin
        shadow[i] <= '0;
        active[i] <= (i == CTR) ? UNITY : '0;
      end
    end else begin
      state     <= state_next;
      widx      <= widx_next;
      o_swapped <= swap_en;
      o_err     <= err_next;
      if (wr_en) begin
        shadow[widx] <= i_wr_data;
      end
      if (swap_en) begin
        for (int i = 0; i < NCOEFF; i++) begin
          active[i] <= shadow[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NCOEFF; g++) begin : g_pack
    assign o_coeff[NBCOEFF*(g+1)-1 -: NBCOEFF] = active[g];
  end

endmodule

// File: tb/tb_fir_coeff_ctrl.sv
// tb/tb_fir_coeff_ctrl.sv - directed self-checking bench for fir_coeff_ctrl
module tb_fir_coeff_ctrl;

  localparam int NCOEFF   = 9;
  localparam int NBCOEFF  = 7;
  localparam int NBFCOEFF = 5;
  localparam int OS_DIV   = 2;
  localparam int W        = NCOEFF * NBCOEFF;

  logic               clk = 1'b0;
  logic               reset;
  logic               i_run;
  logic               i_load_start;
  logic               i_wr_valid;
  logic [NBCOEFF-1:0] i_wr_data;
  logic               o_wr_ready;
  logic               i_commit;
  logic [W-1:0]       o_coeff;
  logic               o_enable;
  logic               o_busy;
  logic               o_swapped;
  logic               o_err;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [W-1:0] bank1, bank2, bank3, bank4, bank5, default_bank;

  always #5 clk = ~clk;

  fir_coeff_ctrl #(
    .NCOEFF   (NCOEFF),
    .NBCOEFF  (NBCOEFF),
    .NBFCOEFF (NBFCOEFF),
    .OS_DIV   (OS_DIV)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .i_run        (i_run),
    .i_load_start (i_load_start),
    .i_wr_valid   (i_wr_valid),
    .i_wr_data    (i_wr_data),
    .o_wr_ready   (o_wr_ready),
    .i_commit     (i_commit),
    .o_coeff      (o_coeff),
    .o_enable     (o_enable),
    .o_busy       (o_busy),
    .o_swapped    (o_swapped),
    .o_err        (o_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_bank(input logic [W-1:0] bank, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      i_wr_valid = 1'b1;
      i_wr_data  = bank[i*NBCOEFF +: NBCOEFF];
      tick();
    end
    i_wr_valid = 1'b0;
    i_wr_data  = '0;
  endtask

  task automatic pulse_load_start();
    i_load_start = 1'b1;
    tick();
    i_load_start = 1'b0;
  endtask

  task automatic pulse_commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
  endtask

  // Observes up to 20 edges for the swap; reports whether it happened and
  // whether the edge it happened on carried o_enable with o_swapped following.
  task automatic wait_swap(output bit seen, output bit on_strobe);
    logic         en_before;
    logic [W-1:0] prev;
    seen      = 1'b0;
    on_strobe = 1'b0;
    for (int k = 0; k < 20; k++) begin
      en_before = o_enable;
      prev      = o_coeff;
      tick();
      if (o_coeff !== prev || o_swapped === 1'b1) begin
        seen      = 1'b1;
        on_strobe = en_before && (o_swapped === 1'b1);
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_run = 1'b0; i_load_start = 1'b0; i_wr_valid = 1'b0;
    i_wr_data = '0; i_commit = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    tests_run++;
    if (o_coeff !== default_bank) begin
      tests_failed++;
      $display("FAIL reset_coeff: got %h expected %h", o_coeff, default_bank);
    end
    tests_run++;
    if (o_enable !== 1'b0 || o_busy !== 1'b0 || o_wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_flags: enable/busy/ready got %b%b%b expected 000", o_enable, o_busy, o_wr_ready);
    end
    tests_run++;
    if (o_swapped !== 1'b0 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_pulses: swapped/err got %b%b expected 00", o_swapped, o_err);
    end
  endtask

  task automatic test_strobe();
    logic exp_seq [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    i_run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      tests_run++;
      if (o_enable !== exp_seq[k]) begin
        tests_failed++;
        $display("FAIL strobe_edge%0d: got %b expected %b", k + 1, o_enable, exp_seq[k]);
      end
    end
    i_run = 1'b0;
    tick();
    tests_run++;
    if (o_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL strobe_stop: got %b expected 0", o_enable);
    end
    tick();
    tests_run++;
    if (o_enable !== 1'b0) begin
      tests_failed++;
      $display("FAIL strobe_stay_low: got %b expected 0", o_enable);
    end
  endtask

  task automatic test_idle_commit();
    i_commit = 1'b1;
    tick();
    i_commit = 1'b0;
    tests_run++;
    if (o_err !== 1'b1 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_commit_err: err/busy got %b%b expected 10", o_err, o_busy);
    end
    tick();
    tests_run++;
    if (o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_err_width: got %b expected 0", o_err);
    end
  endtask

  task automatic test_full_load_swap();
    bit seen, on_strobe;
    i_run = 1'b1;
    pulse_load_start();
    tests_run++;
    if (o_busy !== 1'b1 || o_wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL load_entry: busy/ready got %b%b expected 11", o_busy, o_wr_ready);
    end
    write_bank(bank1, 0, NCOEFF - 1);
    tests_run++;
    if (o_busy !== 1'b1 || o_wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL armed_entry: busy/ready got %b%b expected 10", o_busy, o_wr_ready);
    end
    tests_run++;
    if (o_coeff !== default_bank) begin
      tests_failed++;
      $display("FAIL active_before_commit: got %h expected %h", o_coeff, default_bank);
    end
    pulse_commit();
    tests_run++;
    if (o_busy !== 1'b1 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL commit_armed: busy/err got %b%b expected 10", o_busy, o_err);
    end
    wait_swap(seen, on_strobe);
    tests_run++;
    if (!seen || !on_strobe) begin
      tests_failed++;
      $display("FAIL swap1_timing: seen/on_strobe got %b%b expected 11", seen, on_strobe);
    end
    tests_run++;
    if (o_coeff !== bank1 || o_busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL swap1_coeff: got %h busy %b expected %h busy 0", o_coeff, o_busy, bank1);
    end
    tick();
    tests_run++;
    if (o_swapped !== 1'b0) begin
      tests_failed++;
      $display("FAIL swapped_width: got %b expected 0", o_swapped);
    end
  endtask

  task automatic test_early_commit();
    bit seen, on_strobe;
    pulse_load_start();
    write_bank(bank2, 0, 4);
    pulse_commit();
    tests_run++;
    if (o_err !== 1'b1 || o_wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL early_commit: err/ready got %b%b expected 11", o_err, o_wr_ready);
    end
    tick();
    tests_run++;
    if (o_err !== 1'b0 || o_coeff !== bank1) begin
      tests_failed++;
      $display("FAIL early_commit_after: err %b coeff %h expected err 0 coeff %h", o_err, o_coeff, bank1);
    end
    write_bank(bank2, 5, NCOEFF - 1);
    tests_run++;
    if (o_wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_finish_armed: ready got %b expected 0", o_wr_ready);
    end
    pulse_commit();
    wait_swap(seen, on_strobe);
    tests_run++;
    if (!seen || !on_strobe || o_coeff !== bank2) begin
      tests_failed++;
      $display("FAIL swap2: seen %b on_strobe %b coeff %h expected 1 1 %h", seen, on_strobe, o_coeff, bank2);
    end
  endtask

  task automatic test_back_to_back();
    bit seen, on_strobe, stray;
    pulse_load_start();
    write_bank(bank3, 0, NCOEFF - 1);
    i_load_start = 1'b1;
    i_commit     = 1'b1;
    tick();
    i_load_start = 1'b0;
    i_commit     = 1'b0;
    tests_run++;
    if (o_wr_ready !== 1'b1 || o_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL armed_restart: ready/err got %b%b expected 10", o_wr_ready, o_err);
    end
    stray = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (o_swapped !== 1'b0 || o_err !== 1'b0) stray = 1'b1;
    end
    tests_run++;
    if (stray || o_coeff !== bank2) begin
      tests_failed++;
      $display("FAIL armed_restart_noswap: stray %b coeff %h expected 0 %h", stray, o_coeff, bank2);
    end
    // Restart with a word presented in the same cycle: the word must be dropped.
    i_load_start = 1'b1;
    i_wr_valid   = 1'b1;
    i_wr_data    = '0;
    tick();
    i_load_start = 1'b0;
    i_wr_valid   = 1'b0;
    write_bank(bank4, 0, NCOEFF - 2);
    tests_run++;
    if (o_wr_ready !== 1'b1) begin
      tests_failed++;
      $display("FAIL restart_drops_word: ready got %b expected 1", o_wr_ready);
    end
    write_bank(bank4, NCOEFF - 1, NCOEFF - 1);
    tests_run++;
    if (o_wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL reload_armed: ready got %b expected 0", o_wr_ready);
    end
    pulse_commit();
    wait_swap(seen, on_strobe);
    tests_run++;
    if (!seen || !on_strobe || o_coeff !== bank4) begin
      tests_failed++;
      $display("FAIL swap_all_ones: seen %b on_strobe %b coeff %h expected 1 1 %h", seen, on_strobe, o_coeff, bank4);
    end
  endtask

  task automatic test_reset_in_swap();
    bit stray;
    i_run = 1'b0;
    tick(); tick();
    pulse_load_start();
    write_bank(bank5, 0, NCOEFF - 1);
    pulse_commit();
    stray = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_swapped !== 1'b0 || o_busy !== 1'b1 || o_coeff !== bank4) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL swap_hold_no_run: swap or state change seen, busy %b coeff %h expected busy 1 coeff %h", o_busy, o_coeff, bank4);
    end
    reset = 1'b1;
    #1;
    tests_run++;
    if (o_coeff !== default_bank || o_busy !== 1'b0 || o_wr_ready !== 1'b0) begin
      tests_failed++;
      $display("FAIL async_reset: coeff %h busy %b ready %b expected %h 0 0", o_coeff, o_busy, o_wr_ready, default_bank);
    end
    tick();
    reset = 1'b0;
    i_run = 1'b1;
    stray = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (o_swapped !== 1'b0 || o_coeff !== default_bank) stray = 1'b1;
    end
    tests_run++;
    if (stray) begin
      tests_failed++;
      $display("FAIL post_reset_noswap: swap seen, coeff %h expected %h", o_coeff, default_bank);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    default_bank = '0;
    default_bank[4*NBCOEFF +: NBCOEFF] = 7'd32;
    for (int i = 0; i < NCOEFF; i++) begin
      bank1[i*NBCOEFF +: NBCOEFF] = 7'(i + 1);
      bank2[i*NBCOEFF +: NBCOEFF] = 7'(i + 10);
      bank3[i*NBCOEFF +: NBCOEFF] = 7'(i + 20);
      bank4[i*NBCOEFF +: NBCOEFF] = 7'h7F;
      bank5[i*NBCOEFF +: NBCOEFF] = 7'(3 * i + 1);
    end

    test_reset();
    test_strobe();
    test_idle_commit();
    test_full_load_swap();
    test_early_commit();
    test_back_to_back();
    test_reset_in_swap();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
